// File: rtl/manchester_frame_arbiter_pkg.sv
// Shared definitions for the Manchester TX framing arbiter: frame delimiter
// default, FSM state encoding and index-width helper.
package manchester_frame_arbiter_pkg;

    localparam logic [7:0] SYNC_SYMBOL_DEFAULT = 8'hD5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HDR,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/manchester_rr_arbiter.sv
// Combinational round-robin select: first requester at or above ptr, wrapping
// back to source 0.
module manchester_rr_arbiter
    import manchester_frame_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int IDX_W = idx_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    // One extra bit so ptr+offset can exceed NUM_SRC-1 before folding back.
    logic [IDX_W:0] cand;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_SRC)) begin
                cand = cand - (IDX_W+1)'(NUM_SRC);
            end
            if (!gnt_valid && req[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/manchester_frame_arbiter.sv
// Packet-granular round-robin arbiter feeding the Manchester TX escape stage;
// each frame is prefixed with SYNC and a source-ID byte flagged via tuser.
module manchester_frame_arbiter
    import manchester_frame_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_SYMBOL = DATA_WIDTH'(SYNC_SYMBOL_DEFAULT),
    parameter int IFG_CYCLES = 2,
    localparam int IDX_W = idx_width(NUM_SRC)
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_idx
);

    localparam int GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    if (DATA_WIDTH < IDX_W) begin : g_width_check
        $error("manchester_frame_arbiter: DATA_WIDTH must hold a source index");
    end

    state_t                state, state_next;
    logic [IDX_W-1:0]      ptr, ptr_next;
    logic [IDX_W-1:0]      grant_next;
    logic [GAP_W-1:0]      gap_cnt, gap_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  valid_next, last_next, user_next;
    logic                  ld;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid, src_last;
    logic [IDX_W-1:0]      ptr_after;

    manchester_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req       (s_axis_tvalid),
        .ptr       (ptr),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign ld        = !m_axis_tvalid || m_axis_tready;
    assign src_data  = s_axis_tdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign src_valid = s_axis_tvalid[grant_idx];
    assign src_last  = s_axis_tlast[grant_idx];
    assign ptr_after = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            gap_cnt       <= '0;
            grant_idx     <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else begin
            state         <= state_next;
            ptr           <= ptr_next;
            gap_cnt       <= gap_next;
            grant_idx     <= grant_next;
            m_axis_tdata  <= data_next;
            m_axis_tvalid <= valid_next;
            m_axis_tlast  <= last_next;
            m_axis_tuser  <= user_next;
        end
    end

    // A consumed output byte drains to a bubble unless a new byte is loaded over it.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        gap_next      = gap_cnt;
        grant_next    = grant_idx;
        data_next     = m_axis_tdata;
        valid_next    = m_axis_tvalid;
        last_next     = m_axis_tlast;
        user_next     = m_axis_tuser;
        s_axis_tready = '0;
        if (m_axis_tvalid && m_axis_tready) begin
            valid_next = 1'b0;
        end
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_next = arb_idx;
                    state_next = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (ld) begin
                    data_next  = SYNC_SYMBOL;
                    user_next  = 1'b1;
                    last_next  = 1'b0;
                    valid_next = 1'b1;
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (ld) begin
                    data_next  = DATA_WIDTH'(grant_idx);
                    user_next  = 1'b1;
                    last_next  = 1'b0;
                    valid_next = 1'b1;
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // Gated by aresetn so no byte is accepted in a cycle that aborts the frame.
                s_axis_tready[grant_idx] = ld && aresetn;
                if (ld && src_valid) begin
                    data_next  = src_data;
                    last_next  = src_last;
                    user_next  = 1'b0;
                    valid_next = 1'b1;
                    if (src_last) begin
                        ptr_next   = ptr_after;
                        gap_next   = '0;
                        state_next = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (!m_axis_tvalid) begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        gap_next = gap_cnt + GAP_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_manchester_frame_arbiter.sv
// Self-checking bench for manchester_frame_arbiter: queued source packets,
// an output monitor and a round-robin frame model built from the packets sent.
module tb_manchester_frame_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DW      = 8;
    localparam int IDX_W   = 2;
    localparam int IFG     = 2;

    logic                    aclk = 1'b0;
    logic                    aresetn;
    logic [NUM_SRC*DW-1:0]   s_axis_tdata;
    logic [NUM_SRC-1:0]      s_axis_tvalid;
    logic [NUM_SRC-1:0]      s_axis_tready;
    logic [NUM_SRC-1:0]      s_axis_tlast;
    logic [DW-1:0]           m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    m_axis_tlast;
    logic                    m_axis_tuser;
    logic                    busy;
    logic [IDX_W-1:0]        grant_idx;

    always #5 aclk = ~aclk;

    manchester_frame_arbiter #(
        .NUM_SRC     (NUM_SRC),
        .DATA_WIDTH  (DW),
        .SYNC_SYMBOL (8'hD5),
        .IFG_CYCLES  (IFG)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy),
        .grant_idx     (grant_idx)
    );

    typedef struct {
        int         gap;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t       srcq[NUM_SRC][$];
    beat_t       pend[NUM_SRC][$];
    logic [9:0]  got[$];
    int          exp_order[$];
    int          model_ptr = 0;
    int          n_compared = 0;
    int          n_mismatched = 0;
    bit          ready_random = 1'b0;
    int          cyc = 0;

    int                 req_cycle, sync_cycle;
    bit                 req_seen, sync_seen;
    logic [NUM_SRC-1:0] tready_or;
    int                 multi_ready = 0;
    int                 stall_viol = 0;
    int                 bubbles = 0, last_bubbles = -1, idle_cnt = 0, min_gap = 1000, ubytes = 0;
    bit                 in_payload = 1'b0, after_frame = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Source driver: retire handshaken beats, then present the next head (after its pre-gap).
    initial begin
        logic [NUM_SRC-1:0] hs_s;
        beat_t b;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge aclk);
            hs_s = s_axis_tvalid & s_axis_tready & {NUM_SRC{aresetn}};
            @(posedge aclk);
            #1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs_s[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                s_axis_tvalid[i]         = 1'b0;
                s_axis_tlast[i]          = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    if (b.gap > 0) begin
                        b.gap--;
                        srcq[i][0] = b;
                    end else begin
                        s_axis_tvalid[i]         = 1'b1;
                        s_axis_tlast[i]          = b.last;
                        s_axis_tdata[i*DW +: DW] = b.data;
                    end
                end
            end
            m_axis_tready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: collects accepted bytes and frame timing statistics.
    initial begin
        logic [10:0] prev_bundle;
        logic        prev_ready;
        bit          prev_ok;
        prev_ok = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                ubytes = 0; in_payload = 1'b0; after_frame = 1'b0; prev_ok = 1'b0;
            end else begin
                tready_or = tready_or | s_axis_tready;
                if ($countones(s_axis_tready) > 1) multi_ready++;
                if (s_axis_tvalid != '0 && !req_seen) begin req_seen = 1'b1; req_cycle = cyc; end
                if (m_axis_tvalid && !sync_seen) begin sync_seen = 1'b1; sync_cycle = cyc; end
                if (prev_ok && prev_bundle[10] && !prev_ready &&
                    {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_bundle) stall_viol++;
                if (m_axis_tvalid && m_axis_tready) begin
                    got.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
                    if (m_axis_tuser) begin
                        if (ubytes == 0 && after_frame) begin
                            if (idle_cnt < min_gap) min_gap = idle_cnt;
                            after_frame = 1'b0;
                        end
                        ubytes++;
                        if (ubytes == 2) begin in_payload = 1'b1; bubbles = 0; end
                    end else if (m_axis_tlast) begin
                        last_bubbles = bubbles; in_payload = 1'b0; ubytes = 0;
                        after_frame = 1'b1; idle_cnt = 0;
                    end
                end else if (!m_axis_tvalid) begin
                    if (in_payload) bubbles++;
                    if (after_frame) idle_cnt++;
                end
                prev_bundle = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
                prev_ready  = m_axis_tready;
                prev_ok     = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    task automatic pushBeat(input int src, input logic [7:0] data, input logic last, input int gap);
        beat_t b;
        b.data = data; b.last = last; b.gap = gap;
        srcq[src].push_back(b);
        pend[src].push_back(b);
    endtask

    task automatic applyStimulus(input int src, input int len, input int gap_at, input int gap_len);
        for (int k = 0; k < len; k++)
            pushBeat(src, 8'($urandom_range(0, 255)), k == len - 1, (k == gap_at) ? gap_len : 0);
    endtask

    task automatic waitIdle(input string tag, input int maxc);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        while (!done && n < maxc) begin
            tick();
            n++;
            done = !busy && !m_axis_tvalid;
            for (int i = 0; i < NUM_SRC; i++) if (srcq[i].size() > 0) done = 1'b0;
        end
        if (!done) begin
            n_compared++; n_mismatched++;
            $error("[TB] FAIL %s_timeout: observed busy expected idle", tag);
        end
    endtask

    task automatic waitGot(input string tag, input int cnt, input int maxc);
        int n;
        n = 0;
        while (got.size() < cnt && n < maxc) begin tick(); n++; end
        if (got.size() < cnt) begin
            n_compared++; n_mismatched++;
            $error("[TB] FAIL %s_timeout: observed %0d bytes expected %0d", tag, got.size(), cnt);
        end
    endtask

    // Round-robin over whole packets still pending in the model, from model_ptr.
    task automatic computeOrder();
        int cnt[NUM_SRC];
        int c;
        bit any;
        exp_order.delete();
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt[i] = 0;
            for (int k = 0; k < pend[i].size(); k++) if (pend[i][k].last) cnt[i]++;
        end
        do begin
            any = 1'b0;
            for (int k = 0; k < NUM_SRC; k++) begin
                c = (model_ptr + k) % NUM_SRC;
                if (!any && cnt[c] > 0) begin
                    any = 1'b1; cnt[c]--; exp_order.push_back(c);
                    model_ptr = (c + 1) % NUM_SRC;
                end
            end
        end while (any);
    endtask

    task automatic checkOutput(input string tag);
        logic [9:0] exp[$];
        beat_t b;
        int id;
        computeOrder();
        foreach (exp_order[j]) begin
            id = exp_order[j];
            exp.push_back({2'b10, 8'hD5});
            exp.push_back({2'b10, 8'(id)});
            while (pend[id].size() > 0) begin
                b = pend[id].pop_front();
                exp.push_back({1'b0, b.last, b.data});
                if (b.last) break;
            end
        end
        check({tag, "_len"}, got.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            check($sformatf("%s_byte%0d", tag, k), got[k], exp[k]);
        got.delete();
    endtask

    initial begin
        int nlast;
        aresetn = 1'b0;
        tready_or = '0; req_seen = 1'b1; sync_seen = 1'b1;
        repeat (3) tick();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_s_tready", s_axis_tready, 0);
        aresetn = 1'b1;
        tick();

        $display("[TB] all sources, single-byte packets");
        for (int i = 0; i < NUM_SRC; i++) applyStimulus(i, 1, -1, 0);
        applyStimulus(0, 1, -1, 0);
        waitIdle("t2", 300);
        checkOutput("t2");
        check("t2_min_gap", min_gap >= IFG, 1);

        $display("[TB] src2 three-byte packet");
        tready_or = '0; req_seen = 1'b0; sync_seen = 1'b0;
        pushBeat(2, 8'h11, 1'b0, 0);
        pushBeat(2, 8'h22, 1'b0, 0);
        pushBeat(2, 8'h33, 1'b1, 0);
        waitIdle("t1", 200);
        checkOutput("t1");
        check("t1_tready_mask", tready_or, 4'b0100);
        check("t1_latency", sync_cycle - req_cycle, 2);

        $display("[TB] random output ready, 8-byte packet");
        ready_random = 1'b1; stall_viol = 0;
        applyStimulus(3, 8, -1, 0);
        waitIdle("t3", 1000);
        ready_random = 1'b0;
        tick();
        checkOutput("t3");
        check("t3_stall_stable", stall_viol, 0);

        $display("[TB] late request during another frame");
        applyStimulus(1, 6, -1, 0);
        waitGot("t4", 4, 200);
        applyStimulus(3, 2, -1, 0);
        waitIdle("t4", 300);
        checkOutput("t4");

        $display("[TB] source valid gap mid-packet");
        applyStimulus(1, 5, 2, 3);
        waitIdle("t5", 300);
        check("t5_bubbles", last_bubbles, 3);
        check("t5_grant", grant_idx, 1);
        checkOutput("t5");

        $display("[TB] reset during payload");
        applyStimulus(2, 10, -1, 0);
        waitGot("t6", 5, 200);
        aresetn = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin srcq[i].delete(); pend[i].delete(); end
        tick();
        check("t6_tvalid", m_axis_tvalid, 0);
        check("t6_busy", busy, 0);
        check("t6_s_tready", s_axis_tready, 0);
        aresetn = 1'b1;
        model_ptr = 0;
        tick();
        tick();
        nlast = 0;
        foreach (got[k]) if (got[k][8]) nlast++;
        check("t6_no_tlast", nlast, 0);
        got.delete();
        applyStimulus(3, 2, -1, 0);
        applyStimulus(0, 2, -1, 0);
        waitIdle("t6b", 300);
        checkOutput("t6b");

        check("one_hot_tready", multi_ready, 0);
        check("min_gap_final", min_gap >= IFG, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
